// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// Universal shift register with single-cycle load, shift, rotate and
// arithmetic-shift operations. It also has a multi-cycle shift engine that
// moves the register by 'amt' positions, one bit per clock.
//
// Optional feature macro: USR_PARITY_EN
//   When defined, output 'par' is added. It carries the XOR-reduction of q and
//   is registered together with q. When the macro is undefined, the port and
//   its logic are absent.
//
// Parameters
//   WIDTH  register width in bits (>= 2)
//   CNT_W  width of the multi-shift amount input
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset
//   mode   in   single-cycle operation select (ignored while busy)
//   d      in   parallel load data
//   sin    in   serial fill bit for shifts
//   start  in   request a multi-cycle shift of amt positions in direction dir
//   amt    in   multi-shift amount, unsigned
//   dir    in   multi-shift direction: 0 = left, 1 = right
//   q      out  register contents
//   qb     out  registered bitwise complement of q
//   sout   out  bit shifted out by the most recent shift/rotate
//   busy   out  high while a multi-shift is in progress
//   done   out  one-cycle pulse when a multi-shift completes
//   par    out  XOR-reduction of q (only with USR_PARITY_EN)
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             par
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        MD_HOLD  = 3'b000,
        MD_LOAD  = 3'b001,
        MD_SHL   = 3'b010,
        MD_SHR   = 3'b011,
        MD_ROL   = 3'b100,
        MD_ROR   = 3'b101,
        MD_ASR   = 3'b110,
        MD_HOLD2 = 3'b111
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Shift primitives
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                    input logic fill);
        return {v[WIDTH-2:0], fill};
    endfunction

    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                     input logic fill);
        return {fill, v[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] rotate_left(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rotate_right(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    // Arithmetic right shift: the sign bit is replicated into the vacated MSB.
    function automatic logic [WIDTH-1:0] arith_right(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [WIDTH-1:0] qb_q;
    logic             sout_q,  sout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef USR_PARITY_EN
    logic             par_q;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        q_d     = q_q;
        sout_d  = sout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // start takes priority over any single-cycle mode.
                    if (amt != CNT_ZERO) begin
                        state_d = ST_SHIFT;
                        cnt_d   = amt;
                        dir_d   = dir;
                        busy_d  = 1'b1;
                    end else begin
                        // Zero-length request: report completion, leave q alone.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    case (mode_t'(mode))
                        MD_LOAD: q_d = d;
                        MD_SHL: begin
                            q_d    = shift_left(q_q, sin);
                            sout_d = q_q[WIDTH-1];
                        end
                        MD_SHR: begin
                            q_d    = shift_right(q_q, sin);
                            sout_d = q_q[0];
                        end
                        MD_ROL: begin
                            q_d    = rotate_left(q_q);
                            sout_d = q_q[WIDTH-1];
                        end
                        MD_ROR: begin
                            q_d    = rotate_right(q_q);
                            sout_d = q_q[0];
                        end
                        MD_ASR: begin
                            q_d    = arith_right(q_q);
                            sout_d = q_q[0];
                        end
                        default: q_d = q_q;   // MD_HOLD, MD_HOLD2
                    endcase
                end
            end

            ST_SHIFT: begin
                // Fill comes from the live sin, not a value captured at start.
                if (dir_q) begin
                    q_d    = shift_right(q_q, sin);
                    sout_d = q_q[0];
                end else begin
                    q_d    = shift_left(q_q, sin);
                    sout_d = q_q[WIDTH-1];
                end
                cnt_d = cnt_q - CNT_ONE;
                // busy/done are registered, so they are decided one edge
                // ahead: the last shift edge drops busy and raises done.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            q_q     <= '0;
            qb_q    <= '1;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef USR_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
            // Complement is taken from the next value so qb tracks q with no lag.
            qb_q    <= ~q_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef USR_PARITY_EN
            par_q   <= ^q_d;
`endif
        end
    end

    assign q    = q_q;
    assign qb   = qb_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef USR_PARITY_EN
    assign par  = par_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic       start;
    logic [3:0] amt;
    logic       dir;
    logic [7:0] q;
    logic [7:0] qb;
    logic       sout;
    logic       busy;
    logic       done;
`ifdef USR_PARITY_EN
    logic       par;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .d     (d),
        .sin   (sin),
        .start (start),
        .amt   (amt),
        .dir   (dir),
        .q     (q),
        .qb    (qb),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
`ifdef USR_PARITY_EN
        ,
        .par   (par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        mode = 3'b001; d = v; start = 1'b0;
        step();
        mode = 3'b000;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        n_tests++; if (q !== 8'h00)  begin n_fail++; $display("FAIL reset_q got %h exp 00", q); end
        n_tests++; if (qb !== 8'hFF) begin n_fail++; $display("FAIL reset_qb got %h exp FF", qb); end
        n_tests++; if (sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout got %b exp 0", sout); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
`ifdef USR_PARITY_EN
        n_tests++; if (par !== 1'b0) begin n_fail++; $display("FAIL reset_par got %b exp 0", par); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_load_shift;
        load(8'hA5);
        n_tests++; if (q !== 8'hA5)  begin n_fail++; $display("FAIL load_q got %h exp A5", q); end
        n_tests++; if (qb !== 8'h5A) begin n_fail++; $display("FAIL load_qb got %h exp 5A", qb); end
        mode = 3'b010; sin = 1'b1;
        step();
        n_tests++; if (q !== 8'h4B)  begin n_fail++; $display("FAIL shl_q got %h exp 4B", q); end
        n_tests++; if (sout !== 1'b1) begin n_fail++; $display("FAIL shl_sout got %b exp 1", sout); end
        n_tests++; if (qb !== 8'hB4) begin n_fail++; $display("FAIL shl_qb got %h exp B4", qb); end
        mode = 3'b000;
        step();
        n_tests++; if (q !== 8'h4B)  begin n_fail++; $display("FAIL hold_q got %h exp 4B", q); end
        mode = 3'b011; sin = 1'b0;
        step();
        n_tests++; if (q !== 8'h25)  begin n_fail++; $display("FAIL shr_q got %h exp 25", q); end
        n_tests++; if (sout !== 1'b1) begin n_fail++; $display("FAIL shr_sout got %b exp 1", sout); end
        mode = 3'b111;
        step();
        n_tests++; if (q !== 8'h25)  begin n_fail++; $display("FAIL hold7_q got %h exp 25", q); end
        // A load must not disturb sout.
        load(8'h00);
        n_tests++; if (sout !== 1'b1) begin n_fail++; $display("FAIL load_sout got %b exp 1", sout); end
    endtask

    task automatic test_rotate_arith;
        load(8'h81);
        mode = 3'b101;
        step();
        n_tests++; if (q !== 8'hC0)  begin n_fail++; $display("FAIL ror_q got %h exp C0", q); end
        n_tests++; if (sout !== 1'b1) begin n_fail++; $display("FAIL ror_sout got %b exp 1", sout); end
        mode = 3'b110;
        step();
        n_tests++; if (q !== 8'hE0)  begin n_fail++; $display("FAIL asr_q got %h exp E0", q); end
        n_tests++; if (sout !== 1'b0) begin n_fail++; $display("FAIL asr_sout got %b exp 0", sout); end
        mode = 3'b100;
        step();
        n_tests++; if (q !== 8'hC1)  begin n_fail++; $display("FAIL rol_q got %h exp C1", q); end
        n_tests++; if (sout !== 1'b1) begin n_fail++; $display("FAIL rol_sout got %b exp 1", sout); end
        n_tests++; if (qb !== 8'h3E) begin n_fail++; $display("FAIL rol_qb got %h exp 3E", qb); end
        mode = 3'b000;
    endtask

    task automatic test_multi_shift;
        load(8'hF0);
        // mode=010 alongside start: start wins.
        start = 1'b1; amt = 4'd3; dir = 1'b1; sin = 1'b0; mode = 3'b010;
        step();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ms_busy1 got %b exp 1", busy); end
        n_tests++; if (q !== 8'hF0)   begin n_fail++; $display("FAIL ms_q0 got %h exp F0", q); end
        // Inputs changed during SHIFT must be ignored.
        start = 1'b0; mode = 3'b001; d = 8'hFF; dir = 1'b0;
        step();
        n_tests++; if (q !== 8'h78)   begin n_fail++; $display("FAIL ms_q1 got %h exp 78", q); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ms_busy2 got %b exp 1", busy); end
        step();
        n_tests++; if (q !== 8'h3C)   begin n_fail++; $display("FAIL ms_q2 got %h exp 3C", q); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ms_busy3 got %b exp 1", busy); end
        mode = 3'b000;
        step();
        n_tests++; if (q !== 8'h1E)   begin n_fail++; $display("FAIL ms_q3 got %h exp 1E", q); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ms_busy_end got %b exp 0", busy); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ms_done got %b exp 1", done); end
        n_tests++; if (qb !== 8'hE1)  begin n_fail++; $display("FAIL ms_qb got %h exp E1", qb); end
        step();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL ms_done_pulse got %b exp 0", done); end
        n_tests++; if (q !== 8'h1E)   begin n_fail++; $display("FAIL ms_q_idle got %h exp 1E", q); end
    endtask

    task automatic test_back_to_back;
        // amt=0: straight to DONE, q unchanged.
        start = 1'b1; amt = 4'd0; dir = 1'b0; sin = 1'b0;
        step();
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b exp 1", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b exp 0", busy); end
        n_tests++; if (q !== 8'h1E)   begin n_fail++; $display("FAIL zero_q got %h exp 1E", q); end
        // start held through DONE is ignored there, accepted once back in IDLE.
        amt = 4'd2;
        step();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_off got %b exp 0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ign got %b exp 0", busy); end
        step();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b exp 1", busy); end
        start = 1'b0;
        step();
        n_tests++; if (q !== 8'h3C)   begin n_fail++; $display("FAIL b2b_q1 got %h exp 3C", q); end
        step();
        n_tests++; if (q !== 8'h78)   begin n_fail++; $display("FAIL b2b_q2 got %h exp 78", q); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b exp 1", done); end
        step();
    endtask

    task automatic test_flush;
        int cycles;
        load(8'h5A);
        start = 1'b1; amt = 4'd10; dir = 1'b0; sin = 1'b1;
        step();
        start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            step();
        end
        n_tests++; if (cycles !== 10) begin n_fail++; $display("FAIL flush_busy_cycles got %0d exp 10", cycles); end
        n_tests++; if (q !== 8'hFF)   begin n_fail++; $display("FAIL flush_q got %h exp FF", q); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL flush_done got %b exp 1", done); end
        n_tests++; if (sout !== 1'b1) begin n_fail++; $display("FAIL flush_sout got %b exp 1", sout); end
        step();
    endtask

    task automatic test_reset_mid_shift;
        int pulses;
        load(8'h3C);
        start = 1'b1; amt = 4'd5; dir = 1'b0; sin = 1'b0;
        step();                       // first busy cycle
        start = 1'b0;
        step();                       // second busy cycle
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got %b exp 1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (q !== 8'h00)   begin n_fail++; $display("FAIL rmid_q got %h exp 00", q); end
        n_tests++; if (qb !== 8'hFF)  begin n_fail++; $display("FAIL rmid_qb got %h exp FF", qb); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_off got %b exp 0", busy); end
        pulses = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        n_tests++; if (pulses !== 0)  begin n_fail++; $display("FAIL rmid_no_done got %0d exp 0", pulses); end
        n_tests++; if (q !== 8'h00)   begin n_fail++; $display("FAIL rmid_q_after got %h exp 00", q); end
    endtask

`ifdef USR_PARITY_EN
    task automatic test_parity;
        load(8'h07);
        n_tests++; if (par !== 1'b1) begin n_fail++; $display("FAIL par_07 got %b exp 1", par); end
        load(8'h03);
        n_tests++; if (par !== 1'b0) begin n_fail++; $display("FAIL par_03 got %b exp 0", par); end
    endtask
`endif

    initial begin
        rst = 1'b1; mode = 3'b000; d = 8'h00; sin = 1'b0;
        start = 1'b0; amt = 4'd0; dir = 1'b0;
        #2;
        test_reset();
        test_load_shift();
        test_rotate_arith();
        test_multi_shift();
        test_back_to_back();
        test_flush();
        test_reset_mid_shift();
`ifdef USR_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
